monty_red_iter: RTL and testbench

Iterative Montgomery reduction controller for the radix-2^26 datapath. It accepts one K-bit product and drives a free-running single-word reduction stage ITER times, feeding each K-R-bit result back as the next input. It then applies an optional final conditional subtraction and returns the reduced residue over a valid/ready handshake. It sits directly downstream of the multiplier and wraps the word-reduction stage instance.

---
 rtl/monty_pkg.sv | 35 +++
 rtl/monty_cond_sub.sv | 40 ++++
 rtl/monty_red_iter.sv | 161 ++++++++++++++++
 tb/tb_monty_red_iter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/monty_pkg.sv
// -----------------------------------------------------------------------------
// monty_pkg
// Shared definitions for the iterative Montgomery reduction controller:
//   - R            : reduction word size (fixed, radix 2^26)
//   - Q_DEF        : default modulus, qH*2^(R+Y)+1 with qH = 2^26-1, Y = 12
//   - ceil_div     : derives the number of reduction rounds from Q_LEN / R
//   - cnt_w        : counter width helper built on $clog2
//   - state_e      : controller FSM states
// -----------------------------------------------------------------------------
package monty_pkg;

  localparam int          R             = 26;
  localparam int          K_DEF         = 90;
  localparam int          Q_LEN_DEF     = 64;
  localparam logic [63:0] Q_DEF         = 64'hFFFF_FFC0_0000_0001;
  localparam int          STAGE_LAT_DEF = 4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // A counter over n states needs $clog2(n) bits, but never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SUB   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/monty_cond_sub.sv
// -----------------------------------------------------------------------------
// monty_cond_sub
// Registered conditional subtraction: when en_i is high, res_o takes
// (a_i >= Q_EXT) ? a_i - Q_EXT : a_i on the next rising edge, otherwise holds.
// Ports:
//   clk   in  1  clock
//   rst   in  1  asynchronous active-high reset (clears res_o)
//   en_i  in  1  load enable
//   a_i   in  W  value to reduce (< 2*Q_EXT)
//   res_o out W  registered result (< Q_EXT)
// -----------------------------------------------------------------------------
module monty_cond_sub #(
  parameter int           W     = 65,
  parameter logic [W-1:0] Q_EXT = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  output logic [W-1:0] res_o
);

  logic [W-1:0] res_q;
  logic [W-1:0] res_d;

  always_comb begin
    res_d = res_q;
    if (en_i) res_d = (a_i >= Q_EXT) ? (a_i - Q_EXT) : a_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/monty_red_iter.sv
// -----------------------------------------------------------------------------
// monty_red_iter
// Iterative Montgomery reduction controller. Accepts one K-bit product, drives
// an external free-running word-reduction stage ITER times (each round's
// K-R-bit result becomes the next round's input), optionally applies a final
// conditional subtraction, and returns the residue over valid/ready.
//
// Build option: define MONTY_RED_ITER_FINAL_SUB_EN to add the SUB state and
// the monty_cond_sub instance (out_data < Q, one extra cycle of latency).
// Without it out_data is the raw last-round value (< 2Q).
//
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        product valid
//   in_ready   out  1        controller idle, can accept
//   in_data    in   K        product C
//   red_c      out  K        stage input C (0 unless red_issue)
//   red_issue  out  1        red_c carries a live round input
//   red_t      in   K-R      stage output T, STAGE_LAT cycles after red_c
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts
//   out_data   out  Q_LEN+1  reduced residue
// -----------------------------------------------------------------------------
module monty_red_iter
  import monty_pkg::*;
#(
  parameter int               K         = K_DEF,
  parameter int               Q_LEN     = Q_LEN_DEF,
  parameter logic [Q_LEN-1:0] Q         = Q_DEF,
  parameter int               ITER      = ceil_div(Q_LEN, R),
  parameter int               STAGE_LAT = STAGE_LAT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  output logic [K-1:0]     red_c,
  output logic             red_issue,
  input  logic [K-R-1:0]   red_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_LEN:0]   out_data
);

  localparam int                WCNT_W    = cnt_w(STAGE_LAT);
  localparam int                RND_W     = cnt_w(ITER);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(STAGE_LAT - 1);
  localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(ITER - 1);

  state_e            state_q, state_d;
  logic [K-1:0]      acc_q,   acc_d;
  logic [RND_W-1:0]  rnd_q,   rnd_d;
  logic [WCNT_W-1:0] wcnt_q,  wcnt_d;

`ifdef MONTY_RED_ITER_FINAL_SUB_EN
  logic             sub_en;
  logic [Q_LEN:0]   res;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rnd_d     = rnd_q;
    wcnt_d    = wcnt_q;
    in_ready  = 1'b0;
    red_c     = '0;
    red_issue = 1'b0;
    out_valid = 1'b0;
`ifdef MONTY_RED_ITER_FINAL_SUB_EN
    sub_en    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          rnd_d   = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        red_c     = acc_q;
        red_issue = 1'b1;
        wcnt_d    = '0;
        state_d   = ST_WAIT;
      end

      // The stage never stalls, so its output is only meaningful on the one
      // cycle that lines up with this round's issue.
      ST_WAIT: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (wcnt_q == WCNT_LAST) begin
          acc_d = {{R{1'b0}}, red_t};
          rnd_d = rnd_q + RND_W'(1);
          if (rnd_q == RND_LAST) begin
`ifdef MONTY_RED_ITER_FINAL_SUB_EN
            state_d = ST_SUB;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end

`ifdef MONTY_RED_ITER_FINAL_SUB_EN
      ST_SUB: begin
        sub_en  = 1'b1;
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rnd_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rnd_q   <= rnd_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef MONTY_RED_ITER_FINAL_SUB_EN
  // After the last round acc holds a value < 2Q in its low Q_LEN+1 bits.
  monty_cond_sub #(
    .W     (Q_LEN + 1),
    .Q_EXT ({1'b0, Q})
  ) u_cond_sub (
    .clk   (clk),
    .rst   (rst),
    .en_i  (sub_en),
    .a_i   (acc_q[Q_LEN:0]),
    .res_o (res)
  );

  assign out_data = res;
`else
  assign out_data = acc_q[Q_LEN:0];
`endif

endmodule

// File: tb/tb_monty_red_iter.sv
module tb_monty_red_iter;

  localparam int          K    = 90;
  localparam int          ITER = 3;
  localparam int          SL   = 4;
  localparam logic [63:0] QM   = 64'hFFFF_FFC0_0000_0001;
`ifdef MONTY_RED_ITER_FINAL_SUB_EN
  localparam int          LAT  = ITER * (SL + 1) + 2;
`else
  localparam int          LAT  = ITER * (SL + 1) + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [K-1:0]  in_data;
  logic [K-1:0]  red_c;
  logic          red_issue;
  logic [63:0]   red_t;
  logic          out_valid;
  logic          out_ready;
  logic [64:0]   out_data;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [63:0] exp_q[$];
  int          acc_cyc_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  monty_red_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .red_c     (red_c),
    .red_issue (red_issue),
    .red_t     (red_t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // One Montgomery word step: T = (C + m*Q) / 2^26 with m = -C mod 2^26
  // (Q = 1 mod 2^26, so -Q^-1 = -1).
  function automatic logic [63:0] stage_f(input logic [K-1:0] c);
    logic [25:0]  m26;
    logic [127:0] t;
    m26 = -c[25:0];
    t   = ({38'd0, c} + {102'd0, m26} * {64'd0, QM}) >> 26;
    return t[63:0];
  endfunction

  // Free-running behavioural stage with SL register stages.
  logic [63:0] pipe [SL];
  always @(posedge clk) begin
    pipe[0] <= stage_f(red_c);
    for (int i = 1; i < SL; i++) pipe[i] <= pipe[i-1];
  end
  assign red_t = pipe[SL-1];

  // Reference: C * 2^-78 mod Q by repeated modular halving.
  function automatic logic [63:0] ref_red(input logic [K-1:0] c);
    logic [127:0] x;
    x = {38'd0, c} % {64'd0, QM};
    for (int i = 0; i < 78; i++)
      x = x[0] ? ((x + {64'd0, QM}) >> 1) : (x >> 1);
    return x[63:0];
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic check_out(input string name, input logic [64:0] got, input logic [63:0] expv);
`ifdef MONTY_RED_ITER_FINAL_SUB_EN
    check(name, 128'(got), 128'(expv));
`else
    check({name, "_lt2q"}, 128'(got < {QM, 1'b0}), 128'(1));
    check({name, "_mod"}, 128'(got % {1'b0, QM}), 128'(expv));
`endif
  endtask

  // Scoreboard push side: every accepted product enqueues its expected residue.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(ref_red(in_data));
      acc_cyc_q.push_back(cyc + 1);
    end
  end

  // Monitor: compares every fired output against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL stray_output: got out_data=%0h required no output (cycle %0d)", out_data, cyc);
      end else begin
        check_out("result", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic run_timing(input logic [K-1:0] c);
    int   issues[$];
    int   first_ov;
    int   k;
    logic leak;
    in_data = c; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("tm_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    first_ov = -1; k = 0; leak = 1'b0;
    while (first_ov < 0 && k < 60) begin
      @(negedge clk); k++;
      if (red_issue) issues.push_back(k);
      else if (red_c != '0) leak = 1'b1;
      if (out_valid) first_ov = k;
    end
    check("tm_issue_count", 128'(issues.size()), 128'(ITER));
    for (int i = 0; i < issues.size() && i < ITER; i++)
      check("tm_issue_cycle", 128'(issues[i]), 128'(1 + i * (SL + 1)));
    check("tm_red_c_idle", 128'(leak), 128'(0));
    check("tm_out_valid_cycle", 128'(first_ov), 128'(LAT));
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run_stall(input logic [K-1:0] c);
    logic [63:0] e;
    int          k;
    e = ref_red(c);
    in_data = c; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 60) begin @(negedge clk); k++; end
    check("stall_reach_done", 128'(out_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check_out("stall_data", out_data, e);
      check("stall_out_valid", 128'(out_valid), 128'(1));
      check("stall_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("stall_fire_valid", 128'(out_valid), 128'(1));
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("stall_in_ready_after", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic run_reset_abort();
    int n_issue;
    int n_valid;
    in_data = {26'd0, $urandom, $urandom}; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_red_issue", 128'(red_issue), 128'(0));
    check("rst_red_c", 128'(red_c), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    n_issue = 0; n_valid = 0;
    repeat (30) begin
      @(negedge clk);
      if (red_issue) n_issue++;
      if (out_valid) n_valid++;
    end
    check("rst_no_issue", 128'(n_issue), 128'(0));
    check("rst_no_output", 128'(n_valid), 128'(0));
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run_throughput();
    int k;
    acc_cyc_q.delete();
    in_data = {26'd0, $urandom, $urandom}; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    while (acc_cyc_q.size() < 4 && k < 200) begin @(posedge clk); #1; k++; end
    in_valid = 1'b0;
    check("tp_accepts", 128'(acc_cyc_q.size()), 128'(4));
    for (int i = 1; i < acc_cyc_q.size(); i++)
      check("tp_interval", 128'(acc_cyc_q[i] - acc_cyc_q[i-1]), 128'(LAT + 1));
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin @(posedge clk); #1; k++; end
    check("tp_drain", 128'(exp_q.size()), 128'(0));
    out_ready = 1'b0;
  endtask

  // One transaction with random back-pressure and in_valid noise while busy.
  task automatic run_random(input logic [K-1:0] c);
    int k;
    in_data = c; in_valid = 1'b1;
    @(posedge clk); #1;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = {$urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rand_done", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    logic [K-1:0] c;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_red_issue", 128'(red_issue), 128'(0));
    check("reset_red_c", 128'(red_c), 128'(0));
    check("reset_out_data", 128'(out_data), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    run_timing('0);
    run_timing({26'd0, QM});
    run_timing(90'd1);
    run_stall({26'd0, $urandom, $urandom});
    run_reset_abort();
    run_timing({26'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    run_throughput();

    // Random products kept below 2^64 so every intermediate stage result
    // fits the K-R-bit red_t port exactly.
    for (int i = 0; i < 1000; i++) begin
      case (i % 8)
        0:       c = {58'd0, $urandom};
        1:       c = {26'd0, QM - 64'd1 + 64'($urandom_range(0, 2))};
        default: c = {26'd0, $urandom, $urandom};
      endcase
      run_random(c);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
